// File: rtl/mem_arbiter_rr.sv
// N-port arbiter multiplexing cache-side read/write requests onto one main-memory
// four-phase req/ack channel, round-robin or fixed-priority grant, one transaction in flight.
module mem_arbiter_rr #(
   parameter int unsigned NPORTS  = 3,
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter bit          RR_MODE = 1'b1
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic [NPORTS-1:0]                             req,
   input  logic [NPORTS-1:0]                             req_rw,
   input  logic [NPORTS*ADDR_W-1:0]                      req_addr,
   input  logic [NPORTS*WIDTH-1:0]                       req_wdata,
   output logic [NPORTS-1:0]                             ack,
   output logic [NPORTS*WIDTH-1:0]                       rdata,
   output logic                                          mem_enable,
   output logic                                          mem_rw,
   output logic [ADDR_W-1:0]                             mem_addr,
   output logic [WIDTH-1:0]                              mem_data_in,
   input  logic                                          mem_ack,
   input  logic [WIDTH-1:0]                              mem_data_out,
   output logic [((NPORTS > 1) ? $clog2(NPORTS) : 1)-1:0] grant_id,
   output logic                                          busy
);

   localparam int unsigned GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [NPORTS-1:0]         ack_q, ack_d;
   logic [NPORTS*WIDTH-1:0]   rdata_q, rdata_d;
   logic                      mem_enable_q, mem_enable_d;
   logic                      mem_rw_q, mem_rw_d;
   logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]          mem_data_in_q, mem_data_in_d;
   logic [GW-1:0]             grant_id_q, grant_id_d;
   logic                      busy_q, busy_d;
   logic [GW-1:0]             ptr_q, ptr_d;

   logic                      win_found;
   logic [GW-1:0]             win_idx;
   int unsigned               scan_idx;

   // Winner select: scan downward so the last hit is the first port in priority order
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = int'(NPORTS) - 1; k >= 0; k--) begin
         scan_idx = RR_MODE ? ((32'(ptr_q) + 32'(k)) % NPORTS) : 32'(k);
         if (req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = GW'(scan_idx);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ack_d         = ack_q;
      rdata_d       = rdata_q;
      mem_enable_d  = mem_enable_q;
      mem_rw_d      = mem_rw_q;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = mem_data_in_q;
      grant_id_d    = grant_id_q;
      ptr_d         = ptr_q;

      unique case (state_q)
         S_IDLE: begin
            if (win_found && !mem_ack) begin
               mem_rw_d      = req_rw[win_idx];
               mem_addr_d    = req_addr[32'(win_idx)*ADDR_W +: ADDR_W];
               mem_data_in_d = req_wdata[32'(win_idx)*WIDTH +: WIDTH];
               grant_id_d    = win_idx;
               mem_enable_d  = 1'b1;
               state_d       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Port inputs are ignored here; only the memory side can advance
            if (mem_ack) begin
               mem_enable_d      = 1'b0;
               ack_d[grant_id_q] = 1'b1;
               if (mem_rw_q) begin
                  rdata_d[32'(grant_id_q)*WIDTH +: WIDTH] = mem_data_out;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Both sides must return to zero before the channel is reused
            if (!req[grant_id_q] && !mem_ack) begin
               ack_d = '0;
               if (RR_MODE) begin
                  ptr_d = GW'((32'(grant_id_q) + 32'd1) % NPORTS);
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         ack_q         <= '0;
         rdata_q       <= '0;
         mem_enable_q  <= 1'b0;
         mem_rw_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_data_in_q <= '0;
         grant_id_q    <= '0;
         busy_q        <= 1'b0;
         ptr_q         <= '0;
      end else begin
         state_q       <= state_d;
         ack_q         <= ack_d;
         rdata_q       <= rdata_d;
         mem_enable_q  <= mem_enable_d;
         mem_rw_q      <= mem_rw_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_in_q <= mem_data_in_d;
         grant_id_q    <= grant_id_d;
         busy_q        <= busy_d;
         ptr_q         <= ptr_d;
      end
   end

   assign ack         = ack_q;
   assign rdata       = rdata_q;
   assign mem_enable  = mem_enable_q;
   assign mem_rw      = mem_rw_q;
   assign mem_addr    = mem_addr_q;
   assign mem_data_in = mem_data_in_q;
   assign grant_id    = grant_id_q;
   assign busy        = busy_q;

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-port arbiter that multiplexes cache-side memory requests (I-cache read, D-cache read/write, future prefetch/DMA ports) onto a single main-memory req/ack channel.
- Each port issues either a read or a write; one transaction is in flight at a time.
- Grant policy is round-robin or fixed priority.
- Port and memory handshakes are both four-phase, so a held request is never double-issued.

Parameters:
- NPORTS, 3, number of requester ports (>=2).
- WIDTH, 32, data width per transfer.
- ADDR_W, 32, address width.
- RR_MODE, 1, 1 = round-robin grant, 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- req  input  NPORTS  per-port request, held until ack seen
- req_rw  input  NPORTS  per-port direction, 1 = read, 0 = write
- req_addr  input  NPORTS*ADDR_W  per-port address, port i in bits [i*ADDR_W +: ADDR_W]
- req_wdata  input  NPORTS*WIDTH  per-port write data, same packing
- ack  output  NPORTS  per-port completion, held until that port drops req
- rdata  output  NPORTS*WIDTH  per-port read data, valid while ack[i] high
- mem_enable  output  1  memory request
- mem_rw  output  1  1 = read, 0 = write
- mem_addr  output  ADDR_W  memory address
- mem_data_in  output  WIDTH  write data to memory
- mem_ack  input  1  memory completion
- mem_data_out  input  WIDTH  read data from memory
- grant_id  output  $clog2(NPORTS)  currently granted port (valid when busy)
- busy  output  1  high when state != IDLE

Behaviour:
- Reset:
  - all outputs 0, rdata 0, rr pointer 0, state IDLE.
  - Reset mid-transaction abandons it: no ack is issued, and mem_enable drops the cycle after reset is sampled.
- States: IDLE, ISSUE, DONE. All outputs are registered.
- IDLE:
  - If any req is high and mem_ack==0, select winner g.
  - RR_MODE=1: first asserted port scanning ptr, ptr+1, ... modulo NPORTS.
  - RR_MODE=0: lowest asserted index.
  - Latch req_rw[g], req_addr[g], req_wdata[g] into mem_rw/mem_addr/mem_data_in; set grant_id=g, mem_enable=1; go to ISSUE.
  - A request sampled high in cycle 0 gives mem_enable high in cycle 1.
- ISSUE:
  - Hold mem_enable and the latched fields stable; ignore all port input changes.
  - On mem_ack==1: mem_enable<=0; ack[g]<=1; if mem_rw, rdata[g]<=mem_data_out; go to DONE.
  - Latency: ack[g] rises one cycle after mem_ack is sampled.
- DONE:
  - Hold ack[g].
  - When req[g]==0 and mem_ack==0: ack[g]<=0; if RR_MODE, ptr<=(g+1) mod NPORTS; go to IDLE.
  - Minimum idle gap between grants is one cycle (the IDLE cycle).
- rdata[i] holds its value until the next completed read on port i; writes never modify rdata.
- Only one ack bit is ever high. No port is granted while another port's ack is high.
- If req[g] drops during ISSUE (protocol violation), the memory transaction still completes, ack[g] pulses, and DONE exits once mem_ack falls.
- Simultaneous requests: exactly one grant per the policy. Losers stay pending with no ack.
- Round-robin fairness: with all NPORTS requesting continuously, each port is granted once every NPORTS transactions.
- ptr wraps from NPORTS-1 to 0.
- A new request on the same port as the last grant is eligible only after DONE exits and req has been seen low at least once.

Test Plan:
- Single read, port 1: addr=0x100, memory acks after 3 cycles with 0xDEADBEEF -> mem_enable=1, mem_rw=1, mem_addr=0x100 in cycle 1; ack[1] one cycle after mem_ack; rdata[1]=0xDEADBEEF; other rdata unchanged.
- Single write, port 2: addr=0x40, data=0x12345678 -> mem_rw=0, mem_data_in=0x12345678; ack[2] asserted; rdata[2] unchanged.
- RR_MODE=1, ports 0, 1, 2 request simultaneously and re-request after each ack -> grant order 0,1,2,0,1,2 and grant_id matches each transaction.
- RR_MODE=0, ports 0 and 2 request continuously -> port 0 always wins; port 2 starves, which confirms the fixed policy.
- Requester holds req high for 5 cycles after ack -> ack stays high and no second mem_enable occurs until req drops; then IDLE.
- Reset asserted in ISSUE with mem_enable=1 -> next cycle all outputs 0 and ptr=0; a later request on port 2 is served normally with grant_id=2.
